// File: rtl/tx_word_pkg.sv
// Shared constants and helpers for the ASCII-hex UART packet transmitter.
package tx_word_pkg;

  // Packet trailer characters.
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  // 8N1 frame: start + 8 data + stop.
  localparam int unsigned FrameBits = 10;

  typedef enum logic {
    StIdle,
    StSend
  } tx_state_e;

  // Uppercase ASCII hex digit for one nibble.
  function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
    if (nibble < 4'd10) begin
      return 8'h30 + {4'h0, nibble};
    end else begin
      return 8'h37 + {4'h0, nibble};
    end
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. A start strobe loads a byte and drives its start bit
// on the same edge; last_bit_o flags the cycle in which the stop bit is on
// the line, so a new start can follow with no idle gap.
module uart_tx_byte
  import tx_word_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [7:0] load_i,
  output logic       last_bit_o,
  output logic       tx_o
);

  localparam logic [3:0] LastCnt   = 4'(FrameBits - 1);
  localparam logic [3:0] DataLimit = 4'd8;

  // cnt_q is the frame position of the bit currently on the line.
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       busy_q, busy_d;
  logic       tx_q, tx_d;

  assign last_bit_o = busy_q && (cnt_q == LastCnt);
  assign tx_o       = tx_q;

  // Next bit on the line: a new start wins over finishing the current stop bit.
  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    busy_d  = busy_q;
    tx_d    = tx_q;
    if (start_i) begin
      tx_d    = 1'b0;
      shift_d = load_i;
      cnt_d   = 4'd0;
      busy_d  = 1'b1;
    end else if (busy_q) begin
      if (cnt_q == LastCnt) begin
        busy_d = 1'b0;
        tx_d   = 1'b1;
        cnt_d  = 4'd0;
      end else begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q < DataLimit) begin
          // Data goes out LSB first.
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end else begin
          tx_d = 1'b1;
        end
      end
    end
  end

  // Serializer state; the line idles high and returns high on reset at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= 4'd0;
      shift_q <= 8'h00;
      busy_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      busy_q  <= busy_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/tx_word.sv
// Streams a RESOLUTION-bit word as an ASCII-hex packet (MS nibble first,
// then CR LF) over a UART line clocked at the baud rate. Packets repeat back
// to back while transmit_enable is high at each packet boundary.
module tx_word
  import tx_word_pkg::*;
#(
  parameter int unsigned RESOLUTION = 16
) (
  input  logic                  uart_clk,
  input  logic                  rst_n,
  output logic                  TX,
  input  logic [RESOLUTION-1:0] tx_data,
  input  logic                  transmit_enable
);

  localparam int unsigned NIBBLES = RESOLUTION / 4;
  localparam int unsigned CHARS   = NIBBLES + 2;
  localparam int unsigned CharW   = $clog2(CHARS);

  localparam logic [CharW-1:0] LastChar = CharW'(CHARS - 1);

  tx_state_e             state_q;
  logic [CharW-1:0]      char_q;
  logic [RESOLUTION-1:0] shadow_q;

  logic                  byte_start;
  logic                  byte_last;
  logic [7:0]            byte_load;
  logic                  last_char;
  logic [RESOLUTION-1:0] sel_word;
  logic [CharW-1:0]      sel_idx;
  logic [3:0]            sel_nib;
  int unsigned           nib_shift;

  assign last_char = (char_q == LastChar);

  // Decide when the serializer starts a new character, and which one.
  // At a packet start the shadow is only being written this edge, so the
  // first character is taken straight from tx_data.
  always_comb begin
    byte_start = 1'b0;
    sel_word   = shadow_q;
    sel_idx    = char_q + CharW'(1);
    unique case (state_q)
      StIdle: begin
        if (transmit_enable) begin
          byte_start = 1'b1;
          sel_word   = tx_data;
          sel_idx    = '0;
        end
      end
      StSend: begin
        if (byte_last) begin
          if (!last_char) begin
            byte_start = 1'b1;
          end else if (transmit_enable) begin
            byte_start = 1'b1;
            sel_word   = tx_data;
            sel_idx    = '0;
          end
        end
      end
      default: begin
        byte_start = 1'b0;
      end
    endcase
  end

  // Nibble select and character encoding for the selected index.
  always_comb begin
    nib_shift = 0;
    if (32'(sel_idx) < NIBBLES) begin
      nib_shift = 4 * (NIBBLES - 1 - 32'(sel_idx));
    end
    sel_nib = 4'(sel_word >> nib_shift);
    if (32'(sel_idx) < NIBBLES) begin
      byte_load = hex_ascii(sel_nib);
    end else if (32'(sel_idx) == NIBBLES) begin
      byte_load = CR;
    end else begin
      byte_load = LF;
    end
  end

  // Packet FSM: character index and the word snapshot for this packet.
  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      char_q   <= '0;
      shadow_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (transmit_enable) begin
            state_q  <= StSend;
            char_q   <= '0;
            shadow_q <= tx_data;
          end
        end
        StSend: begin
          if (byte_last) begin
            if (!last_char) begin
              char_q <= char_q + CharW'(1);
            end else if (transmit_enable) begin
              char_q   <= '0;
              shadow_q <= tx_data;
            end else begin
              state_q <= StIdle;
              char_q  <= '0;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          char_q  <= '0;
        end
      endcase
    end
  end

  uart_tx_byte u_byte (
    .clk_i      (uart_clk),
    .rst_ni     (rst_n),
    .start_i    (byte_start),
    .load_i     (byte_load),
    .last_bit_o (byte_last),
    .tx_o       (TX)
  );

endmodule

// File: tb/tb_tx_word.sv
// Bench for tx_word: two instances (16-bit and 8-bit words) checked every
// cycle against a queue-of-bits line model, plus decoded-byte checks.
module tb_tx_word;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en16 = 1'b0;
  logic        en8 = 1'b0;
  logic [15:0] d16 = '0;
  logic [7:0]  d8 = '0;
  logic        tx16;
  logic        tx8;

  always #5 clk = ~clk;

  tx_word #(.RESOLUTION(16)) dut16 (
    .uart_clk        (clk),
    .rst_n           (rst_n),
    .TX              (tx16),
    .tx_data         (d16),
    .transmit_enable (en16)
  );

  tx_word #(.RESOLUTION(8)) dut8 (
    .uart_clk        (clk),
    .rst_n           (rst_n),
    .TX              (tx8),
    .tx_data         (d8),
    .transmit_enable (en8)
  );

  int    vectors = 0;
  int    miscompares = 0;
  bit    q16[$];
  bit    q8[$];
  logic  exp16 = 1'b1;
  logic  exp8 = 1'b1;
  logic  cap16[$];
  logic  cap8[$];
  string hexdig = "0123456789ABCDEF";

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Append the whole line waveform of one packet to the chosen model queue.
  task automatic push_packet(input int which, input logic [15:0] w, input int nib);
    logic [7:0] chars[$];
    logic [7:0] c;
    int k;
    for (int i = 0; i < nib; i++) begin
      k = int'((w >> (4 * (nib - 1 - i))) & 16'hF);
      chars.push_back(hexdig[k]);
    end
    chars.push_back(8'h0D);
    chars.push_back(8'h0A);
    foreach (chars[i]) begin
      c = chars[i];
      if (which == 16) q16.push_back(1'b0); else q8.push_back(1'b0);
      for (int b = 0; b < 8; b++) begin
        if (which == 16) q16.push_back(c[b]); else q8.push_back(c[b]);
      end
      if (which == 16) q16.push_back(1'b1); else q8.push_back(1'b1);
    end
  endtask

  // One clock edge of the line model: a packet may begin only once the
  // previous one has fully drained.
  task automatic model_edge();
    if (!rst_n) begin
      q16.delete();
      q8.delete();
      exp16 = 1'b1;
      exp8  = 1'b1;
    end else begin
      if (q16.size() == 0 && en16) push_packet(16, d16, 4);
      if (q8.size() == 0 && en8) push_packet(8, {8'h00, d8}, 2);
      exp16 = (q16.size() != 0) ? q16.pop_front() : 1'b1;
      exp8  = (q8.size() != 0) ? q8.pop_front() : 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("tx16_line", 32'(tx16), 32'(exp16));
    check("tx8_line", 32'(tx8), 32'(exp8));
    cap16.push_back(tx16);
    cap8.push_back(tx8);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [7:0] dec(input int which, input int off);
    logic [7:0] v;
    for (int b = 0; b < 8; b++) begin
      v[b] = (which == 16) ? cap16[off + 1 + b] : cap8[off + 1 + b];
    end
    return v;
  endfunction

  logic [7:0] bytes_1a2f[6];
  logic [7:0] bytes_9c[4];
  logic [7:0] bytes_zero[6];
  logic [7:0] bytes_ones[6];
  logic [7:0] bytes_beef[6];
  logic [9:0] frame_31;

  initial begin
    bytes_1a2f = '{8'h31, 8'h41, 8'h32, 8'h46, 8'h0D, 8'h0A};
    bytes_9c   = '{8'h39, 8'h43, 8'h0D, 8'h0A};
    bytes_zero = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A};
    bytes_ones = '{8'h46, 8'h46, 8'h46, 8'h46, 8'h0D, 8'h0A};
    bytes_beef = '{8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
    frame_31   = 10'b1001100010;

    // Reset held, then released with enable low.
    steps(3);
    rst_n = 1'b1;
    steps(5);

    // Single packet: 16'h1A2F and 8'h9C, enable for one cycle only.
    cap16.delete();
    cap8.delete();
    d16 = 16'h1A2F;
    en16 = 1'b1;
    d8 = 8'h9C;
    en8 = 1'b1;
    step();
    en16 = 1'b0;
    en8 = 1'b0;
    d16 = 16'($urandom);
    d8 = 8'($urandom);
    steps(69);
    for (int i = 0; i < 6; i++) check("bytes_1a2f", 32'(dec(16, 10 * i)), 32'(bytes_1a2f[i]));
    for (int i = 0; i < 10; i++) check("frame0_bits", 32'(cap16[i]), 32'(frame_31[i]));
    for (int i = 60; i < 70; i++) check("idle_after_60", 32'(cap16[i]), 32'd1);
    for (int i = 0; i < 4; i++) check("bytes_9c", 32'(dec(8, 10 * i)), 32'(bytes_9c[i]));
    for (int i = 40; i < 70; i++) check("idle_after_40", 32'(cap8[i]), 32'd1);

    // Asynchronous reset mid-frame, then long idle with enable low.
    d16 = 16'($urandom);
    en16 = 1'b1;
    step();
    en16 = 1'b0;
    steps(12);
    #2 rst_n = 1'b0;
    #1 check("rst_async_tx16", 32'(tx16), 32'd1);
    check("rst_async_tx8", 32'(tx8), 32'd1);
    q16.delete();
    q8.delete();
    exp16 = 1'b1;
    exp8 = 1'b1;
    steps(2);
    rst_n = 1'b1;
    steps(100);

    // Snapshot: data changes mid-packet, second packet picks up the new word.
    cap16.delete();
    d16 = 16'h0000;
    en16 = 1'b1;
    steps(5);
    d16 = 16'hFFFF;
    steps(56);
    en16 = 1'b0;
    steps(70);
    for (int i = 0; i < 6; i++) check("bytes_zero", 32'(dec(16, 10 * i)), 32'(bytes_zero[i]));
    for (int i = 0; i < 6; i++) check("bytes_ones", 32'(dec(16, 60 + 10 * i)), 32'(bytes_ones[i]));

    // Late disable at cycle 30.
    d16 = 16'($urandom);
    en16 = 1'b1;
    steps(30);
    en16 = 1'b0;
    steps(70);

    // Continuous mode: three back-to-back BEEF packets.
    cap16.delete();
    d16 = 16'hBEEF;
    en16 = 1'b1;
    steps(125);
    en16 = 1'b0;
    steps(70);
    check("start_0", 32'(cap16[0]), 32'd0);
    check("start_60", 32'(cap16[60]), 32'd0);
    check("start_120", 32'(cap16[120]), 32'd0);
    check("idle_180", 32'(cap16[180]), 32'd1);
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 6; i++) begin
        check("bytes_beef", 32'(dec(16, 60 * p + 10 * i)), 32'(bytes_beef[i]));
      end
    end

    // Enable high during the final stop bit but low at the ending edge.
    en16 = 1'b1;
    step();
    en16 = 1'b0;
    steps(58);
    en16 = 1'b1;
    step();
    en16 = 1'b0;
    steps(6);
    // Enable high only at the packet-ending edge: next packet follows.
    en16 = 1'b1;
    step();
    en16 = 1'b0;
    steps(59);
    en16 = 1'b1;
    step();
    en16 = 1'b0;
    steps(70);

    // Randomized enables and data on both instances.
    for (int n = 0; n < 3000; n++) begin
      en16 = ($urandom_range(0, 15) == 0);
      en8  = ($urandom_range(0, 11) == 0);
      d16  = 16'($urandom);
      d8   = 8'($urandom);
      step();
    end
    en16 = 1'b0;
    en8 = 1'b0;
    steps(80);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
